// File: rtl/rgb2ycbcr_pkg.sv
// Shared constants for the RGB -> YCbCr converter: BT.601 full-range Q8
// coefficients, rounding/offset constants, control-word layout and the clamp helper.
package rgb2ycbcr_pkg;

  localparam int PIX_W = 8;
  localparam int SUM_W = 18;
  localparam int FRAC  = 8;

  localparam int Y_R  = 77;
  localparam int Y_G  = 150;
  localparam int Y_B  = 29;
  localparam int CB_R = -43;
  localparam int CB_G = -85;
  localparam int CB_B = 128;
  localparam int CR_R = 128;
  localparam int CR_G = -107;
  localparam int CR_B = -21;

  localparam int RND   = 128;
  localparam int C_OFF = 32896;

  localparam int CTRL_W  = 36;
  localparam int WID_MSB = 35;
  localparam int WID_LSB = 20;
  localparam int HGT_MSB = 19;
  localparam int HGT_LSB = 4;
  localparam int DIM_W   = 16;

  localparam logic [DIM_W-1:0] DEF_WIDTH  = 16'd1920;
  localparam logic [DIM_W-1:0] DEF_HEIGHT = 16'd1080;

  // Drop the Q8 fraction and saturate to an unsigned pixel.
  function automatic logic [PIX_W-1:0] clamp8(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] sh;
    localparam logic signed [SUM_W-1:0] MAXV = 255;
    localparam logic signed [SUM_W-1:0] MINV = 0;
    sh = s >>> FRAC;
    if (sh < MINV)      return '0;
    else if (sh > MAXV) return '1;
    else                return sh[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/rgb2ycbcr_dot3.sv
// One output channel: three coefficient products, signed sum plus offset,
// then shift/clamp -- one register per stage, each loaded by its stage enable.
module ycc_dot3
  import rgb2ycbcr_pkg::*;
#(
  parameter int KR  = 0,
  parameter int KG  = 0,
  parameter int KB  = 0,
  parameter int OFS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1,
  input  logic             en2,
  input  logic             en3,
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] res
);

  localparam logic signed [SUM_W-1:0] KR_S  = SUM_W'(KR);
  localparam logic signed [SUM_W-1:0] KG_S  = SUM_W'(KG);
  localparam logic signed [SUM_W-1:0] KB_S  = SUM_W'(KB);
  localparam logic signed [SUM_W-1:0] OFS_S = SUM_W'(OFS);

  logic signed [SUM_W-1:0] pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [PIX_W-1:0]        res_q, res_d;

  always_comb begin
    pr_d  = pr_q;
    pg_d  = pg_q;
    pb_d  = pb_q;
    sum_d = sum_q;
    res_d = res_q;
    if (en1) begin
      pr_d = $signed({{(SUM_W-PIX_W){1'b0}}, r}) * KR_S;
      pg_d = $signed({{(SUM_W-PIX_W){1'b0}}, g}) * KG_S;
      pb_d = $signed({{(SUM_W-PIX_W){1'b0}}, b}) * KB_S;
    end
    if (en2) sum_d = pr_q + pg_q + pb_q + OFS_S;
    if (en3) res_d = clamp8(sum_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_q  <= '0;
      pg_q  <= '0;
      pb_q  <= '0;
      sum_q <= '0;
      res_q <= '0;
    end else begin
      pr_q  <= pr_d;
      pg_q  <= pg_d;
      pb_q  <= pb_d;
      sum_q <= sum_d;
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: rtl/rgb2ycbcr.sv
// RGB -> YCbCr (or gray) converter: 3-stage elastic pipeline with collapsing
// bubbles, plus a one-cycle control-word forwarder that ignores pixel backpressure.
module rgb2ycbcr
  import rgb2ycbcr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter bit GRAY  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*DEPTH-1:0]   sink_data,
  input  logic                 sink_valid,
  output logic                 sink_ready,
  output logic [3*DEPTH-1:0]   source_data,
  output logic                 source_valid,
  input  logic                 source_ready,
  input  logic [CTRL_W-1:0]    control_in_data,
  input  logic                 control_in_valid,
  output logic [CTRL_W-1:0]    control_out_data,
  output logic                 control_out_valid,
  output logic [DIM_W-1:0]     frame_width,
  output logic [DIM_W-1:0]     frame_height
);

  logic [3:1]          vld_q, vld_d, adv, en;
  logic [CTRL_W-1:0]   ctrl_data_q, ctrl_data_d;
  logic                ctrl_vld_q, ctrl_vld_d;
  logic [DIM_W-1:0]    width_q, width_d, height_q, height_d;
  logic [DEPTH-1:0]    y, cb, cr, r, g, b;

  assign r = sink_data[3*DEPTH-1 -: DEPTH];
  assign g = sink_data[2*DEPTH-1 -: DEPTH];
  assign b = sink_data[DEPTH-1:0];

  always_comb begin
    adv[3] = !vld_q[3] || source_ready;
    adv[2] = !vld_q[2] || adv[3];
    adv[1] = !vld_q[1] || adv[2];
    en     = adv & {vld_q[2:1], sink_valid};
    vld_d  = vld_q;
    if (adv[1]) vld_d[1] = sink_valid;
    if (adv[2]) vld_d[2] = vld_q[1];
    if (adv[3]) vld_d[3] = vld_q[2];
  end

  always_comb begin
    ctrl_data_d = control_in_data;
    ctrl_vld_d  = control_in_valid;
    width_d     = width_q;
    height_d    = height_q;
    if (control_in_valid) begin
      width_d  = control_in_data[WID_MSB:WID_LSB];
      height_d = control_in_data[HGT_MSB:HGT_LSB];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      ctrl_data_q <= '0;
      ctrl_vld_q  <= 1'b0;
      width_q     <= DEF_WIDTH;
      height_q    <= DEF_HEIGHT;
    end else begin
      vld_q       <= vld_d;
      ctrl_data_q <= ctrl_data_d;
      ctrl_vld_q  <= ctrl_vld_d;
      width_q     <= width_d;
      height_q    <= height_d;
    end
  end

  ycc_dot3 #(.KR(Y_R),  .KG(Y_G),  .KB(Y_B),  .OFS(RND))   u_y  (
    .clk(clk), .rst(rst), .en1(en[1]), .en2(en[2]), .en3(en[3]),
    .r(r), .g(g), .b(b), .res(y));
  ycc_dot3 #(.KR(CB_R), .KG(CB_G), .KB(CB_B), .OFS(C_OFF)) u_cb (
    .clk(clk), .rst(rst), .en1(en[1]), .en2(en[2]), .en3(en[3]),
    .r(r), .g(g), .b(b), .res(cb));
  ycc_dot3 #(.KR(CR_R), .KG(CR_G), .KB(CR_B), .OFS(C_OFF)) u_cr (
    .clk(clk), .rst(rst), .en1(en[1]), .en2(en[2]), .en3(en[3]),
    .r(r), .g(g), .b(b), .res(cr));

  // Outputs are forced to their reset values for the whole time rst is high,
  // including the first cycle before the synchronous clear has landed.
  always_comb begin
    sink_ready        = adv[1] || rst;
    source_valid      = vld_q[3] && !rst;
    source_data       = '0;
    control_out_data  = '0;
    control_out_valid = 1'b0;
    frame_width       = DEF_WIDTH;
    frame_height      = DEF_HEIGHT;
    if (!rst) begin
      source_data       = GRAY ? {y, y, y} : {y, cb, cr};
      control_out_data  = ctrl_data_q;
      control_out_valid = ctrl_vld_q;
      frame_width       = width_q;
      frame_height      = height_q;
    end
  end

endmodule

// File: tb/tb_rgb2ycbcr.sv
// Scoreboard bench for rgb2ycbcr: color (GRAY=0) and gray (GRAY=1) instances
// share stimulus; expected pixels come from an integer reference model.
module tb_rgb2ycbcr;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sink_data;
  logic        sink_valid, sink_ready, g_sink_ready;
  logic [23:0] source_data, g_source_data;
  logic        source_valid, g_source_valid;
  logic        source_ready;
  logic [35:0] control_in_data, control_out_data, g_control_out_data;
  logic        control_in_valid, control_out_valid, g_control_out_valid;
  logic [15:0] frame_width, frame_height, g_frame_width, g_frame_height;

  int          checks = 0;
  int          failures = 0;
  logic [23:0] sb[$];
  logic [23:0] out_log[$];
  bit          rand_rdy = 1'b0;
  bit          stall = 1'b0;
  logic [23:0] stall_data;

  always #5 clk = ~clk;

  rgb2ycbcr #(.DEPTH(8), .GRAY(1'b0)) dut (
    .clk(clk), .rst(rst), .sink_data(sink_data), .sink_valid(sink_valid),
    .sink_ready(sink_ready), .source_data(source_data), .source_valid(source_valid),
    .source_ready(source_ready), .control_in_data(control_in_data),
    .control_in_valid(control_in_valid), .control_out_data(control_out_data),
    .control_out_valid(control_out_valid), .frame_width(frame_width),
    .frame_height(frame_height));

  rgb2ycbcr #(.DEPTH(8), .GRAY(1'b1)) dut_gray (
    .clk(clk), .rst(rst), .sink_data(sink_data), .sink_valid(sink_valid),
    .sink_ready(g_sink_ready), .source_data(g_source_data), .source_valid(g_source_valid),
    .source_ready(source_ready), .control_in_data(control_in_data),
    .control_in_valid(control_in_valid), .control_out_data(g_control_out_data),
    .control_out_valid(g_control_out_valid), .frame_width(g_frame_width),
    .frame_height(g_frame_height));

  function automatic int clip(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  function automatic logic [23:0] model(input logic [23:0] p);
    int r, g, b, y, cb, cr;
    r  = int'(p[23:16]);
    g  = int'(p[15:8]);
    b  = int'(p[7:0]);
    y  = clip((77 * r + 150 * g + 29 * b + 128) >>> 8);
    cb = clip((-43 * r - 85 * g + 128 * b + 32896) >>> 8);
    cr = clip((128 * r - 107 * g - 21 * b + 32896) >>> 8);
    return {y[7:0], cb[7:0], cr[7:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    if (rand_rdy) source_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard: outputs that will transfer on the next edge are popped and compared.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        checks++;
        if (!(source_valid === 1'b1 && source_data === stall_data)) begin
          failures++;
          $display("FAIL hold_stable got v=%b d=%h exp v=1 d=%h", source_valid, source_data, stall_data);
        end
      end
      if (source_valid && source_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got=%h exp=none", source_data);
        end else begin
          logic [23:0] exp;
          exp = sb.pop_front();
          if (source_data !== exp) begin
            failures++;
            $display("FAIL pixel_data got=%h exp=%h", source_data, exp);
          end
        end
        out_log.push_back(source_data);
      end
      stall      = source_valid && !source_ready;
      stall_data = source_data;
      if (sink_valid && sink_ready) sb.push_back(model(sink_data));
    end
  end

  task automatic drive_px(input logic [23:0] px);
    int n;
    n = 0;
    sink_data  = px;
    sink_valid = 1'b1;
    @(negedge clk);
    while (!sink_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!sink_ready) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout got=stalled exp=accept px=%h", px);
    end
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    source_ready = 1'b1;
    while ((sb.size() != 0 || source_valid) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0 || source_valid) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (source_valid !== 1'b0) begin failures++; $display("FAIL rst_src_valid got=%b exp=0", source_valid); end
    if (source_data !== 24'h0) begin failures++; $display("FAIL rst_src_data got=%h exp=0", source_data); end
    if (control_out_valid !== 1'b0) begin failures++; $display("FAIL rst_ctrl_valid got=%b exp=0", control_out_valid); end
    if (control_out_data !== 36'h0) begin failures++; $display("FAIL rst_ctrl_data got=%h exp=0", control_out_data); end
    if (sink_ready !== 1'b1) begin failures++; $display("FAIL rst_sink_ready got=%b exp=1", sink_ready); end
    if (frame_width !== 16'd1920) begin failures++; $display("FAIL rst_width got=%0d exp=1920", frame_width); end
    if (frame_height !== 16'd1080) begin failures++; $display("FAIL rst_height got=%0d exp=1080", frame_height); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_latency_white();
    bit [2:0] seen;
    source_ready = 1'b1;
    drive_px(24'hFFFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen[i] = source_valid;
      if (i == 2) begin
        checks += 2;
        if (source_data !== 24'hFF8080) begin failures++; $display("FAIL white_color got=%h exp=FF8080", source_data); end
        if (!(g_source_valid === 1'b1 && g_source_data === 24'hFFFFFF)) begin
          failures++; $display("FAIL white_gray got v=%b d=%h exp v=1 d=FFFFFF", g_source_valid, g_source_data);
        end
      end
    end
    checks++;
    if (seen !== 3'b100) begin failures++; $display("FAIL latency got=%b exp=100", seen); end
    drain();
  endtask

  task automatic test_colors();
    out_log.delete();
    source_ready = 1'b1;
    drive_px(24'hFF0000);
    drive_px(24'h0000FF);
    drive_px(24'h000000);
    drain();
    checks += 4;
    if (out_log.size() != 3) begin failures++; $display("FAIL colors_count got=%0d exp=3", out_log.size()); end
    if (out_log[0] !== 24'h4D55FF) begin failures++; $display("FAIL red got=%h exp=4D55FF", out_log[0]); end
    if (out_log[1] !== 24'h1DFF6B) begin failures++; $display("FAIL blue got=%h exp=1DFF6B", out_log[1]); end
    if (out_log[2] !== 24'h008080) begin failures++; $display("FAIL black got=%h exp=008080", out_log[2]); end
  endtask

  task automatic test_random_stream();
    out_log.delete();
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) drive_px(24'($urandom));
    drain();
    checks++;
    if (out_log.size() != 100) begin failures++; $display("FAIL stream_count got=%0d exp=100", out_log.size()); end
  endtask

  task automatic test_backpressure();
    int  acc;
    bit  nxt, last_rdy;
    acc = 0;
    out_log.delete();
    source_ready = 1'b0;
    sink_data    = 24'($urandom);
    sink_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nxt      = sink_ready;
      last_rdy = sink_ready;
      if (nxt) acc++;
      @(posedge clk);
      #1;
      if (nxt) sink_data = 24'($urandom);
    end
    checks += 2;
    if (acc != 3) begin failures++; $display("FAIL bp_accepted got=%0d exp=3", acc); end
    if (last_rdy !== 1'b0) begin failures++; $display("FAIL bp_sink_ready got=%b exp=0", last_rdy); end
    sink_valid   = 1'b0;
    source_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (sink_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", sink_ready); end
    drain();
    checks++;
    if (out_log.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", out_log.size()); end
  endtask

  task automatic test_control();
    logic [35:0] word;
    word = {16'd640, 16'd480, 4'hA};
    out_log.delete();
    source_ready     = 1'b0;
    control_in_data  = word;
    control_in_valid = 1'b1;
    sink_data        = 24'h00FF00;
    sink_valid       = 1'b1;
    @(negedge clk);
    checks += 2;
    if (sink_ready !== 1'b1) begin failures++; $display("FAIL ctrl_no_stall got=%b exp=1", sink_ready); end
    if (control_out_valid !== 1'b0) begin failures++; $display("FAIL ctrl_early got=%b exp=0", control_out_valid); end
    @(posedge clk);
    #1;
    control_in_valid = 1'b0;
    control_in_data  = 36'h0;
    sink_valid       = 1'b0;
    @(negedge clk);
    checks += 4;
    if (control_out_valid !== 1'b1) begin failures++; $display("FAIL ctrl_valid got=%b exp=1", control_out_valid); end
    if (control_out_data !== word) begin failures++; $display("FAIL ctrl_data got=%h exp=%h", control_out_data, word); end
    if (frame_width !== 16'd640) begin failures++; $display("FAIL ctrl_width got=%0d exp=640", frame_width); end
    if (frame_height !== 16'd480) begin failures++; $display("FAIL ctrl_height got=%0d exp=480", frame_height); end
    @(negedge clk);
    checks++;
    if (control_out_valid !== 1'b0) begin failures++; $display("FAIL ctrl_pulse got=%b exp=0", control_out_valid); end
    drain();
    checks += 2;
    if (out_log.size() != 1) begin failures++; $display("FAIL ctrl_px_count got=%0d exp=1", out_log.size()); end
    if (out_log[0] !== 24'h952B15) begin failures++; $display("FAIL ctrl_px got=%h exp=952B15", out_log[0]); end
  endtask

  task automatic test_reset_midflight();
    source_ready = 1'b0;
    drive_px(24'h123456);
    drive_px(24'h808080);
    drive_px(24'hABCDEF);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (source_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", source_valid); end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    source_ready = 1'b1;
    out_log.delete();
    sink_data    = 24'hFFFFFF;
    sink_valid   = 1'b1;
    @(negedge clk);
    checks += 3;
    if (source_valid !== 1'b0) begin failures++; $display("FAIL post_rst_valid got=%b exp=0", source_valid); end
    if (sink_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", sink_ready); end
    if (frame_width !== 16'd1920) begin failures++; $display("FAIL post_rst_width got=%0d exp=1920", frame_width); end
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    repeat (10) @(negedge clk);
    drain();
    checks += 2;
    if (out_log.size() != 1) begin failures++; $display("FAIL post_rst_count got=%0d exp=1", out_log.size()); end
    if (out_log[0] !== 24'hFF8080) begin failures++; $display("FAIL post_rst_px got=%h exp=FF8080", out_log[0]); end
  endtask

  initial begin
    rst              = 1'b1;
    sink_data        = 24'h0;
    sink_valid       = 1'b0;
    source_ready     = 1'b1;
    control_in_data  = 36'h0;
    control_in_valid = 1'b0;
    test_reset();
    test_latency_white();
    test_colors();
    test_random_stream();
    test_backpressure();
    test_control();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
